// File: rtl/axi_rd_slave_sram.sv
// AXI read-channel (AR/R) slave in front of a single-port SRAM with 1-cycle read latency.
// Beats are issued one per cycle while the response path has room and return through a 2-entry FIFO.
module axi_rd_slave_sram #(
    parameter int MEM_AW = 10,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              ram_en,
    output logic [MEM_AW-1:0] ram_addr,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
    } beat_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Burst context
    state_e          state_q;
    logic            arready_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     addr_q;
    logic [7:0]      len_q;
    logic [7:0]      cnt_q;
    logic [2:0]      size_q;
    logic            fixed_q;
    logic            slverr_q;

    // Beat whose RAM read is in flight this cycle
    logic            inf_vld_q;
    logic            inf_ram_q;
    logic            inf_last_q;
    logic [ID_W-1:0] inf_id_q;
    logic [1:0]      inf_resp_q;

    beat_t           fifo_q [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;

    beat_t           inf_beat;
    beat_t           head;
    logic            r_valid;
    logic            pop;
    logic            fifo_pop;
    logic            fifo_push;
    logic            issue;
    logic            decerr;
    logic            ram_en_d;
    logic [1:0]      beat_resp;
    logic [2:0]      occ;

    // NOTE: every always_comb output gets a default on every path so no latch is inferred.
    always_comb begin
        inf_beat.id   = inf_id_q;
        inf_beat.data = inf_ram_q ? ram_rdata : 32'd0;
        inf_beat.resp = inf_resp_q;
        inf_beat.last = inf_last_q;

        r_valid = (count_q != 2'd0) || inf_vld_q;
        if (count_q != 2'd0) begin
            head = fifo_q[rd_ptr_q];
        end else if (inf_vld_q) begin
            head = inf_beat;
        end else begin
            head = '0;
        end

        pop       = r_valid && rready;
        fifo_pop  = pop && (count_q != 2'd0);
        fifo_push = inf_vld_q && !(pop && (count_q == 2'd0));

        // Occupancy after this cycle's pop must leave room for the beat about to be read
        occ   = 3'(count_q) + 3'(inf_vld_q) - 3'(pop);
        issue = (state_q == S_ISSUE) && (occ < 3'd2);

        decerr = |addr_q[31:MEM_AW+2];
        if (slverr_q) begin
            beat_resp = RESP_SLVERR;
        end else if (decerr) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_resp = RESP_OKAY;
        end
        ram_en_d = issue && (beat_resp == RESP_OKAY);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            fixed_q   <= 1'b0;
            slverr_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arvalid && arready_q) begin
                        state_q   <= S_ISSUE;
                        arready_q <= 1'b0;
                        id_q      <= arid;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        cnt_q     <= '0;
                        size_q    <= arsize;
                        fixed_q   <= (arburst == 2'd0);
                        slverr_q  <= arburst[1] || (arsize > 3'd2);
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (!fixed_q) begin
                            addr_q <= addr_q + (32'd1 << size_q);
                        end
                        if (cnt_q == len_q) begin
                            state_q   <= S_IDLE;
                            arready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    arready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            inf_vld_q  <= 1'b0;
            inf_ram_q  <= 1'b0;
            inf_last_q <= 1'b0;
            inf_id_q   <= '0;
            inf_resp_q <= '0;
        end else begin
            inf_vld_q  <= issue;
            inf_ram_q  <= ram_en_d;
            inf_last_q <= (cnt_q == len_q);
            inf_id_q   <= id_q;
            inf_resp_q <= beat_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_q[wr_ptr_q] <= inf_beat;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot};

    assign arready  = arready_q;
    assign rvalid   = r_valid;
    assign rid      = head.id;
    assign rdata    = head.data;
    assign rresp    = head.resp;
    assign rlast    = head.last;
    assign ram_en   = ram_en_d;
    assign ram_addr = addr_q[MEM_AW+1:2];

endmodule

// File: tb/tb_axi_rd_slave_sram.sv
// Bench for axi_rd_slave_sram: a behavioural beat/RAM-access model checked every cycle,
// directed timing checks with literal expectations, then randomized bursts with random rready.
module tb_axi_rd_slave_sram;

    localparam int MEM_AW = 10;
    localparam int ID_W   = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic            ram_en;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]     ram_rdata;

    logic [31:0]     mem [0:(1<<MEM_AW)-1];

    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    bit              rand_rr = 1'b0;

    logic [38:0]     exp_q [$];
    logic [9:0]      ram_q [$];
    logic            stalled = 1'b0;
    logic [38:0]     held;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data valid the cycle after ram_en
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    axi_rd_slave_sram #(.MEM_AW(MEM_AW), .ID_W(ID_W)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'b0000), .arprot(3'b000),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats of one burst, derived from address arithmetic alone
    function automatic void model_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  resp;
        for (int i = 0; i <= int'(len); i++) begin
            a = (burst == 2'd0) ? addr : addr + 32'(i) * (32'd1 << size);
            if (burst[1] || size > 3'd2) resp = 2'd2;
            else if (a[31:12] != 20'd0)  resp = 2'd3;
            else                         resp = 2'd0;
            d = (resp == 2'd0) ? mem[a[11:2]] : 32'd0;
            exp_q.push_back({id, d, resp, (i == int'(len))});
            if (resp == 2'd0) ram_q.push_back(a[11:2]);
        end
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            ram_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("r_hold", 64'({rvalid, rid, rdata, rresp, rlast}), 64'({1'b1, held}));
            if (ram_en) begin
                if (ram_q.size() == 0) check("ram_en_extra", 64'(ram_en), 64'(0));
                else check("ram_addr", 64'(ram_addr), 64'(ram_q.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) check("r_extra_beat", 64'(rvalid), 64'(0));
                else check("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(exp_q.pop_front()));
            end
            stalled = rvalid && !rready;
            held    = {rid, rdata, rresp, rlast};
            if (arvalid && arready) model_ar(arid, araddr, arlen, arsize, arburst);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rr) rready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic goto_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Call only just after a posedge; returns the handshake cycle in t
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int t);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = -1;
        for (int k = 0; k < 5000 && t < 0; k++) begin
            @(negedge clk);
            if (arready) t = cyc;
            step();
        end
        arvalid = 1'b0;
        if (t < 0) check("ar_accept_timeout", 64'(arready), 64'(1));
    endtask

    task automatic drain();
        int k = 0;
        while (k < 3000) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rvalid && arready) break;
            k++;
            step();
        end
        check("drain_beats_left", 64'(exp_q.size()), 64'(0));
        check("drain_reads_left", 64'(ram_q.size()), 64'(0));
        step();
    endtask

    initial begin
        int t;
        int r;
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;

        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = $urandom;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b1; resetn = 1'b0;

        repeat (3) step();
        @(negedge clk);
        check("rst_arready", 64'(arready), 64'(0));
        check("rst_rvalid",  64'(rvalid),  64'(0));
        check("rst_ram_en",  64'(ram_en),  64'(0));
        check("rst_rbus",    64'({rid, rdata, rresp, rlast}), 64'(0));
        step();
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arready_after_release", 64'(arready), 64'(1));
        step();

        // Single beat
        mem[4] = 32'hDEADBEEF;
        do_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'd1, t);
        goto_neg(t + 1);
        check("single_ram_en", 64'(ram_en), 64'(1));
        check("single_ram_addr", 64'(ram_addr), 64'(4));
        check("single_no_early_rvalid", 64'(rvalid), 64'(0));
        goto_neg(t + 2);
        check("single_beat", 64'({rvalid, rid, rdata, rresp, rlast}), 64'({1'b1, 4'd3, 32'hDEADBEEF, 2'd0, 1'b1}));
        check("single_arready_back", 64'(arready), 64'(1));
        step();
        drain();

        // INCR burst at full rate
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        do_ar(4'd5, 32'h0, 8'd3, 3'd2, 2'd1, t);
        for (int k = 0; k < 4; k++) begin
            goto_neg(t + 2 + k);
            check("incr_beat", 64'({rvalid, rdata, rlast}), 64'({1'b1, 32'(k + 1), (k == 3)}));
        end
        goto_neg(t + 6);
        check("incr_done", 64'(rvalid), 64'(0));
        step();
        drain();

        // Backpressure window T+3..T+7
        do_ar(4'd7, 32'h0, 8'd3, 3'd2, 2'd1, t);
        goto_neg(t + 2);
        check("bp_beat0", 64'(rdata), 64'(1));
        @(posedge clk); #1; rready = 1'b0;
        for (int c = t + 3; c <= t + 7; c++) begin
            goto_neg(c);
            check("bp_hold", 64'({rvalid, rdata}), 64'({1'b1, 32'd2}));
            if (c >= t + 5) check("bp_ram_idle", 64'(ram_en), 64'(0));
        end
        @(posedge clk); #1; rready = 1'b1;
        goto_neg(t + 8);
        check("bp_release", 64'(rdata), 64'(2));
        step();
        drain();

        // FIXED burst
        mem[2] = 32'hA5;
        do_ar(4'd1, 32'h8, 8'd2, 3'd2, 2'd0, t);
        for (int k = 0; k < 3; k++) begin
            goto_neg(t + 2 + k);
            check("fixed_beat", 64'({rvalid, rdata, rlast}), 64'({1'b1, 32'hA5, (k == 2)}));
        end
        step();
        drain();

        // Decode error: first byte past the RAM
        do_ar(4'd2, 32'h1000, 8'd0, 3'd2, 2'd1, t);
        goto_neg(t + 1);
        check("decerr_no_ram", 64'(ram_en), 64'(0));
        goto_neg(t + 2);
        check("decerr_beat", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, 32'd0, 2'd3, 1'b1}));
        step();
        drain();

        // Unsupported WRAP burst
        do_ar(4'd4, 32'h20, 8'd1, 3'd2, 2'd2, t);
        goto_neg(t + 1);
        check("slverr_no_ram", 64'(ram_en), 64'(0));
        goto_neg(t + 2);
        check("slverr_beat0", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, 32'd0, 2'd2, 1'b0}));
        goto_neg(t + 3);
        check("slverr_beat1", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, 32'd0, 2'd2, 1'b1}));
        step();
        drain();

        // Reset during beat 2 of an 8-beat burst
        for (int i = 16; i < 24; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        do_ar(4'd9, 32'h40, 8'd7, 3'd2, 2'd1, t);
        goto_neg(t + 3);
        @(posedge clk); #1; resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_beat2", 64'({rvalid, rdata}), 64'({1'b1, 32'hC0DE_0012}));
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_cleared", 64'({rvalid, arready}), 64'(0));
        @(negedge clk);
        check("mid_rst_arready", 64'(arready), 64'(1));
        step();
        do_ar(4'd6, 32'h40, 8'd1, 3'd2, 2'd1, t);
        goto_neg(t + 2);
        check("post_rst_beat", 64'({rvalid, rid, rdata}), 64'({1'b1, 4'd6, 32'hC0DE_0010}));
        step();
        drain();

        // Randomized bursts with random backpressure
        rand_rr = 1'b1;
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 3)) step();
            r = $urandom_range(0, 19);
            l = (r == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            b = (r < 6) ? 2'd1 : (r < 8) ? 2'd0 : (r == 8) ? 2'd2 : 2'd3;
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 32'hFFF));
            else if (r == 7) a = 32'hFF0 + 32'($urandom_range(0, 15));
            else if (r == 8) a = $urandom;
            else             a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            do_ar(4'($urandom_range(0, 15)), a, l, s, b, t);
        end
        rand_rr = 1'b0;
        rready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
